// File: rtl/ts_stream_aligner.sv
// MPEG-TS sync acquisition with lock/unlock hysteresis, byte indexing, NM/HEM sync-byte handling
// and a show-ahead FIFO with sticky overflow.
module ts_stream_aligner #(
    parameter int         PKT_LEN    = 188,
    parameter logic [7:0] SYNC_BYTE  = 8'h47,
    parameter int         LOCK_CNT   = 3,
    parameter int         UNLOCK_CNT = 3,
    parameter int         FIFO_DEPTH = 64
) (
    input  logic                          DCLK_IN,
    input  logic                          RST,
    input  logic [7:0]                    DATA_IN,
    input  logic                          DVALID_IN,
    input  logic                          NM_or_HEM,
    input  logic                          RD_REQ,
    output logic [7:0]                    DATA_OUT,
    output logic [7:0]                    BYTE_INDEX,
    output logic                          EMPTY,
    output logic                          SYNC_FOUND,
    output logic                          OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]   FILL_LEVEL
);
    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [7:0] LAST_POS = 8'(PKT_LEN - 1);
    localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_CNT);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCK} state_t;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ data[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'hD5 : 8'h00);
        end
        return c;
    endfunction

    logic       in_valid_reg, in_mode_reg;
    logic [7:0] in_data_reg;

    state_t     state_reg, state_next;
    logic [7:0] pos_reg, pos_next;
    logic [7:0] good_reg, good_next;
    logic [7:0] miss_reg, miss_next;
    logic [7:0] crc_reg, crc_next;

    logic [7:0]  cur_pos;
    logic        at_sync_pos, is_sync, flush, write_ok, wr_en;
    logic [15:0] wr_word;

    assign cur_pos     = (pos_reg == LAST_POS) ? 8'd0 : pos_reg + 8'd1;
    assign at_sync_pos = (cur_pos == 8'd0);
    assign is_sync     = (in_data_reg == SYNC_BYTE);

    always_ff @(posedge DCLK_IN or negedge RST) begin
        if (!RST) begin
            in_valid_reg <= 1'b0;
            in_mode_reg  <= 1'b0;
            in_data_reg  <= 8'd0;
            state_reg    <= ST_HUNT;
            pos_reg      <= 8'd0;
            good_reg     <= 8'd0;
            miss_reg     <= 8'd0;
            crc_reg      <= 8'd0;
        end else begin
            in_valid_reg <= DVALID_IN;
            in_mode_reg  <= NM_or_HEM;
            in_data_reg  <= DATA_IN;
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            good_reg     <= good_next;
            miss_reg     <= miss_next;
            crc_reg      <= crc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        good_next  = good_reg;
        miss_next  = miss_reg;
        crc_next   = crc_reg;
        flush      = 1'b0;
        write_ok   = 1'b0;
        wr_en      = 1'b0;
        wr_word    = 16'd0;
        if (in_valid_reg) begin
            case (state_reg)
                ST_HUNT: begin
                    if (is_sync) begin
                        state_next = ST_VERIFY;
                        pos_next   = 8'd0;
                        good_next  = 8'd1;
                        crc_next   = 8'd0;
                    end
                end
                ST_VERIFY: begin
                    pos_next = cur_pos;
                    crc_next = at_sync_pos ? 8'd0 : crc8_byte(crc_reg, in_data_reg);
                    if (at_sync_pos) begin
                        if (!is_sync) begin
                            flush = 1'b1;
                        end else if (good_reg + 8'd1 == LOCK_N) begin
                            state_next = ST_LOCK;
                            miss_next  = 8'd0;
                            write_ok   = 1'b1;
                        end else begin
                            good_next = good_reg + 8'd1;
                        end
                    end
                end
                ST_LOCK: begin
                    pos_next = cur_pos;
                    crc_next = at_sync_pos ? 8'd0 : crc8_byte(crc_reg, in_data_reg);
                    write_ok = 1'b1;
                    // Flywheel: the pos=0 slot is a sync whatever it holds; only repeated misses unlock.
                    if (at_sync_pos) begin
                        if (is_sync) begin
                            miss_next = 8'd0;
                        end else if (miss_reg + 8'd1 == UNLOCK_N) begin
                            flush    = 1'b1;
                            write_ok = 1'b0;
                        end else begin
                            miss_next = miss_reg + 8'd1;
                        end
                    end
                end
                default: state_next = ST_HUNT;
            endcase
            if (flush) begin
                state_next = ST_HUNT;
                pos_next   = 8'd0;
                good_next  = 8'd0;
                miss_next  = 8'd0;
                crc_next   = 8'd0;
            end
            wr_en   = write_ok && (!at_sync_pos || !in_mode_reg);
            wr_word = at_sync_pos ? {8'd0, crc_reg} : {cur_pos, in_data_reg};
        end
    end

    // FIFO: words live in mem until moved into the head register (show-ahead output).
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   fill_reg, fill_next;
    logic          head_valid_reg, overflow_reg;
    logic [7:0]    data_out_reg, index_reg;
    logic          full, pop, wr_acc, mem_has, load_head;

    assign full      = (fill_reg == FULL_LVL);
    assign pop       = RD_REQ && head_valid_reg;
    assign wr_acc    = wr_en && (!full || pop);
    assign mem_has   = (fill_reg != {{AW{1'b0}}, head_valid_reg});
    assign load_head = (!head_valid_reg || pop) && mem_has;

    always_comb begin
        fill_next = fill_reg;
        if (wr_acc && !pop) begin
            fill_next = fill_reg + 1'b1;
        end else if (!wr_acc && pop) begin
            fill_next = fill_reg - 1'b1;
        end
    end

    always_ff @(posedge DCLK_IN) begin
        if (wr_acc) begin
            mem[wr_ptr_reg] <= wr_word;
        end
    end

    always_ff @(posedge DCLK_IN or negedge RST) begin
        if (!RST) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fill_reg       <= '0;
            head_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            data_out_reg   <= 8'd0;
            index_reg      <= 8'd0;
        end else if (flush) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fill_reg       <= '0;
            head_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            fill_reg <= fill_next;
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (wr_en && !wr_acc) begin
                overflow_reg <= 1'b1;
            end
            if (load_head) begin
                {index_reg, data_out_reg} <= mem[rd_ptr_reg];
                rd_ptr_reg     <= rd_ptr_reg + 1'b1;
                head_valid_reg <= 1'b1;
            end else if (pop) begin
                head_valid_reg <= 1'b0;
            end
        end
    end

    assign DATA_OUT   = data_out_reg;
    assign BYTE_INDEX = index_reg;
    assign EMPTY      = !head_valid_reg;
    assign SYNC_FOUND = (state_reg == ST_LOCK);
    assign OVERFLOW   = overflow_reg;
    assign FILL_LEVEL = fill_reg;
endmodule

// File: tb/tb_ts_stream_aligner.sv
// Directed bench for ts_stream_aligner: expected FIFO words are queued as bytes are driven and
// compared as the head is popped.
module tb_ts_stream_aligner;
    localparam int PKT_LEN    = 188;
    localparam int FIFO_DEPTH = 64;

    logic       DCLK_IN = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] DATA_IN = 8'd0;
    logic       DVALID_IN = 1'b0;
    logic       NM_or_HEM = 1'b0;
    logic       RD_REQ = 1'b0;
    logic [7:0] DATA_OUT, BYTE_INDEX;
    logic       EMPTY, SYNC_FOUND, OVERFLOW;
    logic [6:0] FILL_LEVEL;

    ts_stream_aligner #(
        .PKT_LEN(PKT_LEN), .SYNC_BYTE(8'h47), .LOCK_CNT(3), .UNLOCK_CNT(3), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .DCLK_IN(DCLK_IN), .RST(RST), .DATA_IN(DATA_IN), .DVALID_IN(DVALID_IN),
        .NM_or_HEM(NM_or_HEM), .RD_REQ(RD_REQ), .DATA_OUT(DATA_OUT), .BYTE_INDEX(BYTE_INDEX),
        .EMPTY(EMPTY), .SYNC_FOUND(SYNC_FOUND), .OVERFLOW(OVERFLOW), .FILL_LEVEL(FILL_LEVEL)
    );

    always #5 DCLK_IN = ~DCLK_IN;

    int          checks = 0;
    int          errors = 0;
    bit          rd_en = 1'b0;
    bit          man_pop = 1'b0;
    logic [15:0] exp_q[$];
    logic [7:0]  pay[PKT_LEN];
    logic [7:0]  cur_crc = 8'd0;
    logic [7:0]  prev_crc = 8'd0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-wise CRC-8 (poly 0xD5, init 0, MSB first)
    function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'hD5) : (r << 1);
        return r;
    endfunction

    task automatic gen_payload(input int kind);
        logic [7:0] b;
        cur_crc = 8'd0;
        pay[0] = 8'h47;
        for (int i = 1; i < PKT_LEN; i++) begin
            b = (kind == 1) ? 8'h00 : 8'($urandom_range(0, 255));
            if (b == 8'h47) b = 8'h46;
            pay[i] = b;
            cur_crc = crc_upd(cur_crc, b);
        end
    endtask

    task automatic push_exp(input logic [15:0] w);
        if (rd_en || exp_q.size() < FIFO_DEPTH) exp_q.push_back(w);
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic mode);
        @(negedge DCLK_IN);
        DATA_IN = b;
        DVALID_IN = 1'b1;
        NM_or_HEM = mode;
        @(posedge DCLK_IN);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge DCLK_IN);
            DVALID_IN = 1'b0;
            @(posedge DCLK_IN);
        end
    endtask

    // Sends bytes start..stop-1 of a packet; wr says whether the aligner is expected to write it.
    task automatic send_packet(input logic [7:0] sync, input bit wr, input bit mode0, input bit mode1,
                               input int kind, input int start, input int stop, input int gap);
        logic [7:0] b;
        if (start == 0) gen_payload(kind);
        for (int i = start; i < stop; i++) begin
            b = (i == 0) ? sync : pay[i];
            if (wr) begin
                if (i == 0) begin
                    if (!mode0) push_exp({8'd0, prev_crc});
                end else begin
                    push_exp({8'(i), b});
                end
            end
            drive_byte(b, (i < PKT_LEN / 2) ? mode0 : mode1);
            if (gap > 0) idle(gap);
        end
        if (stop == PKT_LEN) prev_crc = cur_crc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge DCLK_IN);
        DVALID_IN = 1'b0;
        while ((exp_q.size() != 0 || !EMPTY) && n < 2000) begin
            @(posedge DCLK_IN);
            n++;
        end
        #1;
        check("drain_left", 16'(exp_q.size()), 16'd0);
        check("drain_empty", 16'(EMPTY), 16'd1);
        check("drain_fill", 16'(FILL_LEVEL), 16'd0);
    endtask

    // Consumer: compares and pops the head whenever enabled and the FIFO is non-empty.
    initial begin
        logic [15:0] w;
        forever begin
            @(negedge DCLK_IN);
            if (rd_en) begin
                if (!EMPTY) begin
                    if (exp_q.size() == 0) begin
                        check("word_expected", 16'(exp_q.size()), 16'd1);
                    end else begin
                        w = exp_q.pop_front();
                        check("word", {BYTE_INDEX, DATA_OUT}, w);
                    end
                    RD_REQ = 1'b1;
                end else begin
                    RD_REQ = 1'b0;
                end
            end else begin
                RD_REQ = man_pop;
            end
        end
    end

    initial begin
        logic [7:0]  b;
        logic [15:0] w;
        // Reset values
        #3;
        check("rst_data", 16'(DATA_OUT), 16'd0);
        check("rst_index", 16'(BYTE_INDEX), 16'd0);
        check("rst_empty", 16'(EMPTY), 16'd1);
        check("rst_sync", 16'(SYNC_FOUND), 16'd0);
        check("rst_ovf", 16'(OVERFLOW), 16'd0);
        check("rst_fill", 16'(FILL_LEVEL), 16'd0);
        repeat (3) @(posedge DCLK_IN);
        @(negedge DCLK_IN);
        RST = 1'b1;
        @(posedge DCLK_IN);
        #1 rd_en = 1'b1;

        // False sync in HUNT: one 0x47, nothing at spacing 188
        for (int i = 0; i < 250; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h47) b = 8'h46;
            if (i == 10) b = 8'h47;
            drive_byte(b, 1'b0);
        end
        idle(3);
        #1;
        check("false_sync", 16'(SYNC_FOUND), 16'd0);
        check("false_fill", 16'(FILL_LEVEL), 16'd0);
        check("false_empty", 16'(EMPTY), 16'd1);

        // NM lock on the third sync
        send_packet(8'h47, 1'b0, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        send_packet(8'h47, 1'b0, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        #1 check("sf_after_p2", 16'(SYNC_FOUND), 16'd0);
        gen_payload(0);
        push_exp({8'd0, prev_crc});
        drive_byte(8'h47, 1'b0);
        #1 check("sf_pre_lock", 16'(SYNC_FOUND), 16'd0);
        idle(1);
        #1;
        check("sf_lock", 16'(SYNC_FOUND), 16'd1);
        check("first_empty", 16'(EMPTY), 16'd1);
        check("first_fill", 16'(FILL_LEVEL), 16'd1);
        send_packet(8'h47, 1'b1, 1'b0, 1'b0, 0, 1, PKT_LEN, 0);
        send_packet(8'h47, 1'b1, 1'b0, 1'b0, 1, 0, PKT_LEN, 0);   // zero payload
        send_packet(8'h47, 1'b1, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);   // sync word carries CRC 0x00
        // HEM and mid-packet mode switches
        send_packet(8'h47, 1'b1, 1'b1, 1'b1, 0, 0, PKT_LEN, 0);
        send_packet(8'h47, 1'b1, 1'b1, 1'b0, 0, 0, PKT_LEN, 0);
        send_packet(8'h47, 1'b1, 1'b0, 1'b1, 0, 0, PKT_LEN, 0);
        send_packet(8'h47, 1'b1, 1'b1, 1'b1, 0, 0, PKT_LEN, 0);

        // Asynchronous reset mid-packet
        send_packet(8'h47, 1'b1, 1'b0, 1'b0, 0, 0, PKT_LEN / 2, 0);
        #1 check("sf_before_rst", 16'(SYNC_FOUND), 16'd1);
        #1;
        RST = 1'b0;
        DVALID_IN = 1'b0;
        #1;
        check("mid_rst_data", 16'(DATA_OUT), 16'd0);
        check("mid_rst_index", 16'(BYTE_INDEX), 16'd0);
        check("mid_rst_empty", 16'(EMPTY), 16'd1);
        check("mid_rst_sync", 16'(SYNC_FOUND), 16'd0);
        check("mid_rst_ovf", 16'(OVERFLOW), 16'd0);
        check("mid_rst_fill", 16'(FILL_LEVEL), 16'd0);
        exp_q.delete();
        rd_en = 1'b0;
        repeat (3) @(posedge DCLK_IN);
        @(negedge DCLK_IN);
        RST = 1'b1;

        // Overflow with no reader
        send_packet(8'h47, 1'b0, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        send_packet(8'h47, 1'b0, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        send_packet(8'h47, 1'b1, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        #1;
        check("ovf_fill", 16'(FILL_LEVEL), 16'd64);
        check("ovf_flag", 16'(OVERFLOW), 16'd1);
        gen_payload(0);
        drive_byte(8'h47, 1'b0);
        #1;
        check("full_fill", 16'(FILL_LEVEL), 16'd64);
        w = exp_q.pop_front();
        check("full_head", {BYTE_INDEX, DATA_OUT}, w);
        man_pop = 1'b1;
        idle(1);
        #1;
        man_pop = 1'b0;
        exp_q.push_back({8'd0, prev_crc});
        check("full_rw_fill", 16'(FILL_LEVEL), 16'd64);
        check("full_rw_ovf", 16'(OVERFLOW), 16'd1);
        rd_en = 1'b1;
        send_packet(8'h47, 1'b1, 1'b0, 1'b0, 0, 1, PKT_LEN, 0);
        send_packet(8'h47, 1'b1, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);

        // Flywheel: two corrupted syncs are tolerated
        send_packet(8'h00, 1'b1, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        send_packet(8'hB8, 1'b1, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        send_packet(8'h47, 1'b1, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        #1 check("fly_sf", 16'(SYNC_FOUND), 16'd1);
        // Three consecutive misses unlock and flush
        send_packet(8'h00, 1'b1, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        send_packet(8'h12, 1'b1, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        gen_payload(0);
        drive_byte(8'h00, 1'b0);
        #1;
        check("unlock_sf_pre", 16'(SYNC_FOUND), 16'd1);
        check("ovf_sticky", 16'(OVERFLOW), 16'd1);
        idle(1);
        #1;
        check("unlock_sf", 16'(SYNC_FOUND), 16'd0);
        check("unlock_empty", 16'(EMPTY), 16'd1);
        check("unlock_fill", 16'(FILL_LEVEL), 16'd0);
        check("unlock_ovf", 16'(OVERFLOW), 16'd0);
        exp_q.delete();
        send_packet(8'h00, 1'b0, 1'b0, 1'b0, 0, 1, PKT_LEN, 0);
        #1 check("hunt_fill", 16'(FILL_LEVEL), 16'd0);
        // Re-lock after three good syncs
        send_packet(8'h47, 1'b0, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        send_packet(8'h47, 1'b0, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        #1 check("relock_sf_pre", 16'(SYNC_FOUND), 16'd0);
        send_packet(8'h47, 1'b1, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        #1 check("relock_sf", 16'(SYNC_FOUND), 16'd1);

        // Gapped input: one valid byte in three cycles
        send_packet(8'h47, 1'b1, 1'b0, 1'b0, 0, 0, PKT_LEN, 2);
        send_packet(8'h47, 1'b1, 1'b1, 1'b1, 0, 0, PKT_LEN, 2);
        send_packet(8'h47, 1'b1, 1'b0, 1'b0, 0, 0, PKT_LEN, 2);
        #1 check("gap_sf", 16'(SYNC_FOUND), 16'd1);

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
